ring_flasher_trigger: RTL and testbench

- Front-end request generator for ring_flasher: turns a raw, bouncing push-button into the clean, clock-synchronous repeat_signal pulse that starts a flasher sequence.
- Pipeline: 2-flop synchronizer, counter-based debouncer, press-tracking FSM, pulse stretcher, wrapping press counter.
- Sits between the board button pin and ring_flasher.repeat_signal in the top level.

---
 rtl/ring_flasher_trigger.sv | 155 +++++++++++++++
 tb/tb_ring_flasher_trigger.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_flasher_trigger.sv
// Push-button front end for ring_flasher: synchronizer, debouncer, press FSM, pulse stretcher, press counter.
// Optional auto-repeat while held is compiled in with `define RING_FLASHER_TRIGGER_AUTO_REPEAT_EN.
module ring_flasher_trigger #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 4,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  input  logic       enable,
  output logic       repeat_signal,
  output logic       btn_state,
  output logic [7:0] press_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PC_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PC_W-1:0] PULSE_LOAD = PC_W'(PULSE_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || PULSE_CYCLES < 1) begin : g_cfg_err
    $error("ring_flasher_trigger: DEBOUNCE_CYCLES and PULSE_CYCLES must be >= 1");
  end

`ifdef RING_FLASHER_TRIGGER_AUTO_REPEAT_EN
  localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  if (HOLD_CYCLES < 1 || REPEAT_CYCLES <= PULSE_CYCLES) begin : g_rep_cfg_err
    $error("ring_flasher_trigger: need HOLD_CYCLES >= 1 and REPEAT_CYCLES > PULSE_CYCLES");
  end

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT, S_WAIT_REL} state_t;
  logic [TMR_W-1:0] timer_q;
`else
  // Hold/repeat timing is inert here; only obviously nonsensical values are rejected.
  if (HOLD_CYCLES < 0 || REPEAT_CYCLES < 0) begin : g_rep_cfg_err
    $error("ring_flasher_trigger: HOLD_CYCLES/REPEAT_CYCLES must not be negative");
  end

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_WAIT_REL} state_t;
`endif

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_state_q, btn_state_d;
  state_t          state_q;
  logic [PC_W-1:0] pulse_cnt_q;
  logic            repeat_q;
  logic [7:0]      press_cnt_q;
  logic            fire_press, fire;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_cnt_d    = '0;
    btn_state_d = btn_state_q;
    if (sync2_q != btn_state_q) begin
      if (db_cnt_q == DB_LAST) btn_state_d = ~btn_state_q;
      else                     db_cnt_d    = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_cnt_q    <= '0;
      btn_state_q <= 1'b0;
    end else begin
      sync1_q     <= btn_in;
      sync2_q     <= sync1_q;
      db_cnt_q    <= db_cnt_d;
      btn_state_q <= btn_state_d;
    end
  end

  always_comb begin
    fire_press = enable & btn_state_q & (state_q == S_IDLE);
    fire       = fire_press;
`ifdef RING_FLASHER_TRIGGER_AUTO_REPEAT_EN
    if (enable && btn_state_q) begin
      if (state_q == S_HELD   && timer_q == HOLD_LAST) fire = 1'b1;
      if (state_q == S_REPEAT && timer_q == REP_LAST)  fire = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pulse_cnt_q <= '0;
      repeat_q    <= 1'b0;
      press_cnt_q <= '0;
`ifdef RING_FLASHER_TRIGGER_AUTO_REPEAT_EN
      timer_q     <= '0;
`endif
    end else if (!enable) begin
      // A press already in progress must be released before it can count again.
      state_q     <= btn_state_q ? S_WAIT_REL : S_IDLE;
      pulse_cnt_q <= '0;
      repeat_q    <= 1'b0;
    end else begin
      if (fire) begin
        pulse_cnt_q <= PULSE_LOAD;
        repeat_q    <= 1'b1;
      end else if (pulse_cnt_q != '0) begin
        pulse_cnt_q <= pulse_cnt_q - 1'b1;
        repeat_q    <= (pulse_cnt_q != PC_W'(1));
      end else begin
        repeat_q    <= 1'b0;
      end
      if (fire_press) press_cnt_q <= press_cnt_q + 8'd1;

      case (state_q)
        S_IDLE: begin
          if (btn_state_q) state_q <= S_HELD;
`ifdef RING_FLASHER_TRIGGER_AUTO_REPEAT_EN
          timer_q <= '0;
`endif
        end
        S_HELD: begin
          if (!btn_state_q) state_q <= S_IDLE;
`ifdef RING_FLASHER_TRIGGER_AUTO_REPEAT_EN
          else if (timer_q == HOLD_LAST) begin
            state_q <= S_REPEAT;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`endif
        end
`ifdef RING_FLASHER_TRIGGER_AUTO_REPEAT_EN
        S_REPEAT: begin
          if (!btn_state_q)             state_q <= S_IDLE;
          else if (timer_q == REP_LAST) timer_q <= '0;
          else                          timer_q <= timer_q + 1'b1;
        end
`endif
        S_WAIT_REL: begin
          if (!btn_state_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign repeat_signal = repeat_q;
  assign btn_state     = btn_state_q;
  assign press_count   = press_cnt_q;

endmodule

// File: tb/tb_ring_flasher_trigger.sv
// Self-checking bench for ring_flasher_trigger: timestamp-based reference model plus directed and random stimulus.
module tb_ring_flasher_trigger;

  localparam int D = 16;
  localparam int P = 4;
  localparam int H = 64;
  localparam int R = 32;
`ifdef RING_FLASHER_TRIGGER_AUTO_REPEAT_EN
  localparam int CLEAN_EXTRA = 5;
`else
  localparam int CLEAN_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_in = 1'b0;
  logic       enable = 1'b0;
  logic       repeat_signal;
  logic       btn_state;
  logic [7:0] press_count;

  always #5 clk = ~clk;

  ring_flasher_trigger dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .enable       (enable),
    .repeat_signal(repeat_signal),
    .btn_state    (btn_state),
    .press_count  (press_count)
  );

  int    errors = 0;
  int    checks = 0;
  longint cyc = 0;
  int    rises = 0;
  logic  prev_rep = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: press/fire times as timestamps, pulse high while cycle < pulse_until.
  localparam int M_IDLE = 0, M_ACTIVE = 1, M_BLOCKED = 2;
  bit     m_s1, m_s2, m_st;
  int     m_run, m_mode, m_pc;
  longint m_fire_t, m_pulse_until;

  initial forever begin
    bit old_st, old_s2;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_st = 0; m_run = 0;
      m_mode = M_IDLE; m_pc = 0; m_fire_t = 0; m_pulse_until = 0;
    end else begin
      old_st = m_st;
      old_s2 = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_in;
      if (old_s2 != old_st) begin
        m_run++;
        if (m_run == D) begin
          m_st = !m_st;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (!enable) begin
        m_mode = old_st ? M_BLOCKED : M_IDLE;
        m_pulse_until = 0;
      end else if (!old_st) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
        m_mode = M_ACTIVE;
        m_fire_t = cyc;
        m_pulse_until = cyc + P;
        m_pc = (m_pc + 1) % 256;
      end else if (m_mode == M_ACTIVE) begin
`ifdef RING_FLASHER_TRIGGER_AUTO_REPEAT_EN
        if ((cyc - m_fire_t) >= H && ((cyc - m_fire_t - H) % R) == 0)
          m_pulse_until = cyc + P;
`endif
      end
    end
    #1;
    check("model_repeat_signal", repeat_signal, (cyc < m_pulse_until) ? 1 : 0);
    check("model_btn_state", btn_state, m_st);
    check("model_press_count", press_count, m_pc);
    if (repeat_signal && !prev_rep) rises++;
    prev_rep = repeat_signal;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r0;
    int rel_q[$];
    int exp_q[$];
    int highs;
    logic prv;
    int n;

    // Reset with button already pressed
    rst_n = 0; btn_in = 1; enable = 1;
    tick(3);
    check("rst_repeat", repeat_signal, 0);
    check("rst_btn_state", btn_state, 0);
    check("rst_press_count", press_count, 0);
    rst_n = 1;
    tick(1);
    check("rel_repeat", repeat_signal, 0);
    tick(16);
    check("rel_btn_before", btn_state, 0);
    tick(1);
    check("rel_btn_after", btn_state, 1);
    check("rel_repeat_before", repeat_signal, 0);
    tick(1);
    check("rel_repeat_rise", repeat_signal, 1);
    btn_in = 0;
    tick(40);

    // Clean press, 200 cycles
    r0 = rises;
    check("clean_pc_before", press_count, 1);
    btn_in = 1;
    tick(18);
    check("clean_btn_rise", btn_state, 1);
    check("clean_rep_before", repeat_signal, 0);
    tick(1);
    check("clean_rep_rise", repeat_signal, 1);
    check("clean_pc_after", press_count, 2);
    tick(3);
    check("clean_rep_last", repeat_signal, 1);
    tick(1);
    check("clean_rep_fall", repeat_signal, 0);
    tick(177);
    btn_in = 0;
    tick(17);
    check("clean_btn_hold", btn_state, 1);
    tick(1);
    check("clean_btn_fall", btn_state, 0);
    tick(20);
    check("clean_rises", rises - r0, 1 + CLEAN_EXTRA);

    // Bounce every 5 cycles, then hold
    r0 = rises;
    for (int i = 0; i < 100; i++) begin
      btn_in = ((i / 5) % 2 == 0);
      tick(1);
    end
    check("bounce_no_change", btn_state, 0);
    btn_in = 1;
    tick(18);
    check("bounce_btn_rise", btn_state, 1);
    check("bounce_rep_before", repeat_signal, 0);
    tick(1);
    check("bounce_rep_rise", repeat_signal, 1);
    tick(30);
    btn_in = 0;
    tick(40);
    check("bounce_rises", rises - r0, 1);
    check("bounce_pc", press_count, 3);

    // 256 presses wrap the counter
    r0 = rises;
    repeat (256) begin
      btn_in = 1; tick(25);
      btn_in = 0; tick(25);
    end
    check("wrap_pc", press_count, 3);
    check("wrap_rises", rises - r0, 256);

    // Enable low during press, raised while held
    r0 = rises;
    enable = 0; btn_in = 1;
    tick(30);
    enable = 1;
    tick(30);
    check("en_held_rises", rises - r0, 0);
    check("en_held_pc", press_count, 3);
    btn_in = 0;
    tick(30);
    btn_in = 1;
    tick(19);
    check("en_new_press_rep", repeat_signal, 1);
    check("en_new_press_pc", press_count, 4);
    tick(10);
    btn_in = 0;
    tick(30);
    check("en_new_press_rises", rises - r0, 1);

    // Enable dropped mid-pulse
    btn_in = 1;
    tick(19);
    check("drop_rep_high", repeat_signal, 1);
    enable = 0;
    tick(1);
    check("drop_rep_low", repeat_signal, 0);
    tick(5);
    enable = 1;
    tick(10);
    check("drop_no_refire", repeat_signal, 0);
    btn_in = 0;
    tick(30);

    // Long hold: auto-repeat pattern (or single pulse)
    btn_in = 1;
    tick(18);
    check("auto_btn_rise", btn_state, 1);
    prv = repeat_signal;
    highs = 0;
    for (int rel = 1; rel <= 200; rel++) begin
      tick(1);
      if (repeat_signal) highs++;
      if (repeat_signal && !prv) rel_q.push_back(rel);
      prv = repeat_signal;
    end
`ifdef RING_FLASHER_TRIGGER_AUTO_REPEAT_EN
    exp_q = '{1, 65, 97, 129, 161, 193};
`else
    exp_q = '{1};
`endif
    check("auto_num_pulses", rel_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check("auto_pulse_pos", (i < rel_q.size()) ? rel_q[i] : -1, exp_q[i]);
    check("auto_high_cycles", highs, 4 * exp_q.size());
    check("auto_pc", press_count, 6);
    btn_in = 0;
    tick(40);

    // Reset mid-pulse drops output asynchronously
    btn_in = 1;
    tick(19);
    check("rstmid_rep_high", repeat_signal, 1);
    rst_n = 0;
    #1;
    check("rstmid_rep_low", repeat_signal, 0);
    check("rstmid_pc", press_count, 0);
    tick(2);
    rst_n = 1;
    tick(40);
    btn_in = 0;
    tick(40);

    // Random bursts with occasional enable drops
    n = 0;
    while (n < 3000) begin
      int len;
      len = $urandom_range(1, 40);
      btn_in = $urandom_range(0, 1);
      enable = ($urandom_range(0, 9) != 0);
      tick(len);
      n += len;
    end
    enable = 1;
    btn_in = 0;
    tick(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
